multicycle_sequencer: RTL

Control FSM that sequences the 16-bit multi-cycle datapath. It drives the load enables of the internal holding registers (IR, A/B, ALUOut, MDR), the PC and register-file writes, and the memory request handshake. Each instruction takes 2-5 cycles depending on its class, plus memory wait states. It sits between instruction decode (class input) and the datapath register bank.

---
 rtl/multicycle_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Control FSM for the 16-bit multi-cycle datapath. Walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB and drives the holding-register load
// enables, PC and register-file writes, and the memory request handshake.
// A watchdog counts unanswered memory cycles and faults the block into HALT
// when memory stops responding.
//
// Ports:
//   CLK          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   start        leave IDLE and begin fetching (ignored elsewhere)
//   instr_class  decoded instruction class, sampled in DECODE
//   take_branch  branch condition, sampled in EXEC of a BRANCH
//   mem_ready    memory acknowledge for the current mem_req
//   IR_load, AB_load, ALUOut_load, MDR_load   holding-register load enables
//   PC_write, PC_src                           PC write enable and source select
//   RF_write                                   register-file write enable
//   mem_req, mem_write                         memory request / store qualifier
//   state        current FSM state encoding
//   busy         high outside IDLE and HALT
//   instr_done   one-cycle pulse in the last cycle of each instruction
//   fault        sticky: illegal class or memory timeout
//   retired      completed-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [2:0]       instr_class,
  input  logic             take_branch,
  input  logic             mem_ready,
  output logic             IR_load,
  output logic             AB_load,
  output logic             ALUOut_load,
  output logic             MDR_load,
  output logic             PC_write,
  output logic [1:0]       PC_src,
  output logic             RF_write,
  output logic             mem_req,
  output logic             mem_write,
  output logic [2:0]       state,
  output logic             busy,
  output logic             instr_done,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R   = 3'd0,
    C_ALU_I   = 3'd1,
    C_LOAD    = 3'd2,
    C_STORE   = 3'd3,
    C_BRANCH  = 3'd4,
    C_JUMP    = 3'd5,
    C_HALT    = 3'd6,
    C_ILLEGAL = 3'd7
  } class_t;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  // The stall that would take the counter to MAX_WAIT is the timeout cycle.
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  class_t            cls_q;
  logic [WAIT_W-1:0] wait_q;
  logic              fault_q;
  logic              fault_now;
  logic [CNT_W-1:0]  retired_q;

  // ---------------------------------------------------------------------------
  // Next-state and output decode. Outputs depend only on the registered state
  // and the current inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    IR_load     = 1'b0;
    AB_load     = 1'b0;
    ALUOut_load = 1'b0;
    MDR_load    = 1'b0;
    PC_write    = 1'b0;
    PC_src      = PC_SEQ;
    RF_write    = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    instr_done  = 1'b0;
    fault_now   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        IR_load  = mem_ready;
        PC_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        AB_load = 1'b1;
        case (class_t'(instr_class))
          C_JUMP: begin
            PC_write   = 1'b1;
            PC_src     = PC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          C_HALT: begin
            instr_done = 1'b1;
            state_d    = S_HALT;
          end
          C_ILLEGAL: begin
            fault_now = 1'b1;
            state_d   = S_HALT;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        ALUOut_load = 1'b1;
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            PC_write   = take_branch;
            PC_src     = PC_BRANCH;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        if (cls_q == C_STORE) begin
          mem_write  = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) state_d = S_FETCH;
        end else begin
          MDR_load = mem_ready;
          if (mem_ready) state_d = S_WB;
        end
      end

      S_WB: begin
        RF_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: ;

      default: state_d = S_IDLE;
    endcase

    // Memory watchdog overrides the normal transition. A mem_ready in the
    // limit cycle clears the stall, so the acknowledge wins.
    if (mem_req && !mem_ready && (wait_q == WAIT_LIMIT)) begin
      fault_now = 1'b1;
      state_d   = S_HALT;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU_R;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= class_t'(instr_class);
      wait_q  <= (mem_req && !mem_ready) ? wait_q + 1'b1 : '0;
      if (fault_now)  fault_q   <= 1'b1;
      if (instr_done) retired_q <= retired_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign fault   = fault_q | fault_now;
  assign retired = retired_q;

endmodule
